// File: rtl/alu_arbiter_if.sv
// Request/response and ALU bus shared by two requesters and one ALU.
// slave: arbiter view; master: requester/ALU (bench) view.
interface alu_arbiter_if #(
  parameter int BITS  = 32,
  parameter int CBITS = 4
);
  logic             R0_VALID;
  logic [BITS-1:0]  R0_A;
  logic [BITS-1:0]  R0_B;
  logic [CBITS-1:0] R0_CTL;
  logic             R0_READY;
  logic             R0_RVALID;
  logic [BITS-1:0]  R0_RDATA;
  logic             R0_RREADY;

  logic             R1_VALID;
  logic [BITS-1:0]  R1_A;
  logic [BITS-1:0]  R1_B;
  logic [CBITS-1:0] R1_CTL;
  logic             R1_READY;
  logic             R1_RVALID;
  logic [BITS-1:0]  R1_RDATA;
  logic             R1_RREADY;

  logic [BITS-1:0]  ALU_A;
  logic [BITS-1:0]  ALU_B;
  logic [CBITS-1:0] ALU_CTL;
  logic [BITS-1:0]  ALU_OUT;

  modport slave (
    input  R0_VALID, R0_A, R0_B, R0_CTL, R0_RREADY,
    output R0_READY, R0_RVALID, R0_RDATA,
    input  R1_VALID, R1_A, R1_B, R1_CTL, R1_RREADY,
    output R1_READY, R1_RVALID, R1_RDATA,
    output ALU_A, ALU_B, ALU_CTL,
    input  ALU_OUT
  );

  modport master (
    output R0_VALID, R0_A, R0_B, R0_CTL, R0_RREADY,
    input  R0_READY, R0_RVALID, R0_RDATA,
    output R1_VALID, R1_A, R1_B, R1_CTL, R1_RREADY,
    input  R1_READY, R1_RVALID, R1_RDATA,
    input  ALU_A, ALU_B, ALU_CTL,
    output ALU_OUT
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one combinational ALU.
// ALU_ARB_RR_EN selects round-robin; default is fixed R0 priority.
module alu_arbiter #(
  parameter int BITS  = 32,
  parameter int CBITS = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic             g0;
  logic             g1;
  logic             accept;
  logic             rsp_done;
  logic             tag;
  logic [BITS-1:0]  op_a;
  logic [BITS-1:0]  op_b;
  logic [CBITS-1:0] op_ctl;
  logic [BITS-1:0]  result;

`ifdef ALU_ARB_RR_EN
  logic last;

  // Winner selection: alternate when both ask.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (bus.R0_VALID && bus.R1_VALID) begin
      g0 = last;
      g1 = ~last;
    end else begin
      g0 = bus.R0_VALID;
      g1 = bus.R1_VALID;
    end
  end

  // Remember who won the latest accept.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= g1;
    end
  end
`else
  // Winner selection: R0 always first.
  always_comb begin
    g0 = bus.R0_VALID;
    g1 = ~bus.R0_VALID & bus.R1_VALID;
  end
`endif

  assign accept   = (state == IDLE) && (g0 || g1);
  assign rsp_done = tag ? bus.R1_RREADY : bus.R0_RREADY;

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = EXEC;
      EXEC:    state_n = RESP;
      RESP:    if (rsp_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand latch on accept, result capture after EXEC.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      op_a   <= '0;
      op_b   <= '0;
      op_ctl <= '0;
      tag    <= 1'b0;
      result <= '0;
    end else begin
      if (accept) begin
        op_a   <= g1 ? bus.R1_A   : bus.R0_A;
        op_b   <= g1 ? bus.R1_B   : bus.R0_B;
        op_ctl <= g1 ? bus.R1_CTL : bus.R0_CTL;
        tag    <= g1;
      end
      if (state == EXEC) begin
        result <= bus.ALU_OUT;
      end
    end
  end

  assign bus.R0_READY  = (state == IDLE) & g0;
  assign bus.R1_READY  = (state == IDLE) & g1;
  assign bus.R0_RVALID = (state == RESP) & ~tag;
  assign bus.R1_RVALID = (state == RESP) & tag;
  assign bus.R0_RDATA  = result;
  assign bus.R1_RDATA  = result;
  assign bus.ALU_A     = op_a;
  assign bus.ALU_B     = op_b;
  assign bus.ALU_CTL   = op_ctl;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a scoreboard of responses.
// Honors ALU_ARB_RR_EN to pick arbitration expectations.
module tb_alu_arbiter;

  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [3:0] LT  = 4'd2;
  localparam logic [3:0] XOR = 4'd4;

  typedef struct {
    logic        tag;
    logic [31:0] data;
  } rsp_t;

  logic clk;
  logic rst_n;
  int   pass;
  int   tot;
  int   rd;
  rsp_t exp_q[$];
  rsp_t obs_q[$];

  alu_arbiter_if #(.BITS(32), .CBITS(4)) bus ();

  alu_arbiter #(.BITS(32), .CBITS(4)) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .bus(bus)
  );

  function automatic logic [31:0] alu_f(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  c
  );
    case (c)
      ADD:     return a + b;
      SUB:     return a - b;
      LT:      return {31'd0, $signed(a) < $signed(b)};
      XOR:     return a ^ b;
      default: return a | b;
    endcase
  endfunction

  assign bus.ALU_OUT = alu_f(bus.ALU_A, bus.ALU_B, bus.ALU_CTL);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.R0_RVALID && bus.R0_RREADY)
        obs_q.push_back('{1'b0, bus.R0_RDATA});
      if (bus.R1_RVALID && bus.R1_RREADY)
        obs_q.push_back('{1'b1, bus.R1_RDATA});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.R0_VALID = 0; bus.R0_A = 0; bus.R0_B = 0;
    bus.R0_CTL = 0; bus.R0_RREADY = 0;
    bus.R1_VALID = 0; bus.R1_A = 0; bus.R1_B = 0;
    bus.R1_CTL = 0; bus.R1_RREADY = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tot++; if (bus.ALU_A !== 0)
      $display("FAIL rst_alu_a: got %0h want 0", bus.ALU_A);
    else pass++;
    tot++; if (bus.ALU_B !== 0)
      $display("FAIL rst_alu_b: got %0h want 0", bus.ALU_B);
    else pass++;
    tot++; if (bus.ALU_CTL !== 0)
      $display("FAIL rst_alu_ctl: got %0h want 0", bus.ALU_CTL);
    else pass++;
    tot++; if ({bus.R0_RVALID, bus.R1_RVALID} !== 2'b00)
      $display("FAIL rst_rvalid: got %b%b want 00",
               bus.R0_RVALID, bus.R1_RVALID);
    else pass++;
    tot++; if (bus.R0_RDATA !== 0 || bus.R1_RDATA !== 0)
      $display("FAIL rst_rdata: got %0h/%0h want 0/0",
               bus.R0_RDATA, bus.R1_RDATA);
    else pass++;
    tot++; if ({bus.R0_READY, bus.R1_READY} !== 2'b00)
      $display("FAIL rst_ready: got %b%b want 00",
               bus.R0_READY, bus.R1_READY);
    else pass++;
    tick();
  endtask

  task automatic test_single();
    rsp_t e;
    bus.R0_RREADY = 1; bus.R1_RREADY = 1;
    bus.R0_VALID = 1; bus.R0_A = 5; bus.R0_B = 3; bus.R0_CTL = ADD;
    @(negedge clk);
    tot++; if ({bus.R0_READY, bus.R1_READY} !== 2'b10)
      $display("FAIL single_ready: got %b%b want 10",
               bus.R0_READY, bus.R1_READY);
    else pass++;
    exp_q.push_back('{1'b0, 32'd8});
    tick();
    bus.R0_A = 20; bus.R0_B = 22;
    @(negedge clk);
    tot++; if (bus.R0_READY !== 0 || bus.R0_RVALID !== 0)
      $display("FAIL single_exec: got ready=%b rvalid=%b want 0 0",
               bus.R0_READY, bus.R0_RVALID);
    else pass++;
    tot++; if (bus.ALU_A !== 5 || bus.ALU_B !== 3)
      $display("FAIL single_alu: got %0h/%0h want 5/3",
               bus.ALU_A, bus.ALU_B);
    else pass++;
    tick();
    @(negedge clk);
    tot++; if (bus.R0_RVALID !== 1 || bus.R0_RDATA !== 8)
      $display("FAIL single_resp: got rvalid=%b data=%0h want 1 8",
               bus.R0_RVALID, bus.R0_RDATA);
    else pass++;
    tot++; if (bus.R1_RVALID !== 0 || bus.R0_READY !== 0)
      $display("FAIL single_other: got r1v=%b r0rdy=%b want 0 0",
               bus.R1_RVALID, bus.R0_READY);
    else pass++;
    tick();
    @(negedge clk);
    tot++; if (bus.R0_READY !== 1 || bus.R0_RVALID !== 0)
      $display("FAIL single_idle: got ready=%b rvalid=%b want 1 0",
               bus.R0_READY, bus.R0_RVALID);
    else pass++;
    exp_q.push_back('{1'b0, 32'd42});
    tick();
    bus.R0_VALID = 0;
    repeat (3) tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); tot++;
      if (rd >= obs_q.size())
        $display("FAIL single_sb: got none want %0d:%0h", e.tag, e.data);
      else if (obs_q[rd].tag !== e.tag || obs_q[rd].data !== e.data)
        $display("FAIL single_sb: got %0d:%0h want %0d:%0h",
                 obs_q[rd].tag, obs_q[rd].data, e.tag, e.data);
      else pass++;
      rd++;
    end
    tot++; if (obs_q.size() != rd)
      $display("FAIL single_extra: got %0d rsp want %0d", obs_q.size(), rd);
    else pass++;
  endtask

  task automatic test_arb();
    rsp_t e;
    logic g0, g1, want, r1_seen;
    int   n, last_c, i0, i1;
    do_reset();
    obs_q.delete(); rd = 0;
    n = 0; last_c = 0; i0 = 0; i1 = 0; r1_seen = 0;
    bus.R0_RREADY = 1; bus.R1_RREADY = 1;
    bus.R0_VALID = 1; bus.R0_A = 32'h100; bus.R0_B = 0; bus.R0_CTL = ADD;
    bus.R1_VALID = 1; bus.R1_A = 32'h900; bus.R1_B = 1; bus.R1_CTL = SUB;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      g0 = bus.R0_READY; g1 = bus.R1_READY;
      if (g1) r1_seen = 1;
      if (g0 || g1) begin
`ifdef ALU_ARB_RR_EN
        want = n[0];
`else
        want = 1'b0;
`endif
        tot++; if (g1 !== want || (g0 && g1))
          $display("FAIL arb_grant%0d: got %b%b want r%0d",
                   n, g0, g1, want);
        else pass++;
        if (n > 0) begin
          tot++; if (c - last_c != 3)
            $display("FAIL arb_gap%0d: got %0d want 3", n, c - last_c);
          else pass++;
        end
        if (want)
          exp_q.push_back('{1'b1, alu_f(bus.R1_A, bus.R1_B, SUB)});
        else
          exp_q.push_back('{1'b0, alu_f(bus.R0_A, bus.R0_B, ADD)});
        last_c = c; n++;
      end
      tick();
      if (g0) begin i0++; bus.R0_A = 32'h100 + i0; bus.R0_B = i0 * 3; end
      if (g1) begin i1++; bus.R1_B = i1 + 1; end
    end
    bus.R0_VALID = 0; bus.R1_VALID = 0;
    tot++; if (n != 4)
      $display("FAIL arb_count: got %0d want 4", n);
    else pass++;
`ifndef ALU_ARB_RR_EN
    tot++; if (r1_seen !== 0)
      $display("FAIL arb_r1_ready: got %b want 0", r1_seen);
    else pass++;
`endif
    repeat (4) tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); tot++;
      if (rd >= obs_q.size())
        $display("FAIL arb_sb: got none want %0d:%0h", e.tag, e.data);
      else if (obs_q[rd].tag !== e.tag || obs_q[rd].data !== e.data)
        $display("FAIL arb_sb: got %0d:%0h want %0d:%0h",
                 obs_q[rd].tag, obs_q[rd].data, e.tag, e.data);
      else pass++;
      rd++;
    end
    tot++; if (obs_q.size() != rd)
      $display("FAIL arb_extra: got %0d rsp want %0d", obs_q.size(), rd);
    else pass++;
  endtask

  task automatic test_backpressure();
    rsp_t e;
    bus.R0_VALID = 0; bus.R0_RREADY = 1; bus.R1_RREADY = 0;
    bus.R1_VALID = 1; bus.R1_A = 7; bus.R1_B = 7; bus.R1_CTL = XOR;
    @(negedge clk);
    tot++; if (bus.R1_READY !== 1)
      $display("FAIL bp_accept: got %b want 1", bus.R1_READY);
    else pass++;
    exp_q.push_back('{1'b1, 32'd0});
    tick();
    bus.R1_VALID = 0;
    bus.R0_VALID = 1; bus.R0_A = 2; bus.R0_B = 2; bus.R0_CTL = ADD;
    @(negedge clk);
    tot++; if (bus.R0_READY !== 0)
      $display("FAIL bp_exec_ready: got %b want 0", bus.R0_READY);
    else pass++;
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tot++; if (bus.R1_RVALID !== 1 || bus.R1_RDATA !== 0)
        $display("FAIL bp_hold%0d: got v=%b d=%0h want 1 0",
                 k, bus.R1_RVALID, bus.R1_RDATA);
      else pass++;
      tot++; if (bus.R0_READY !== 0 || bus.ALU_A !== 7 ||
                 bus.ALU_B !== 7 || bus.ALU_CTL !== XOR)
        $display("FAIL bp_stall%0d: got rdy=%b alu=%0h/%0h/%0h want 0 7/7/4",
                 k, bus.R0_READY, bus.ALU_A, bus.ALU_B, bus.ALU_CTL);
      else pass++;
      tick();
    end
    bus.R1_RREADY = 1;
    @(negedge clk);
    tick();
    @(negedge clk);
    tot++; if (bus.R0_READY !== 1 || bus.R1_RVALID !== 0)
      $display("FAIL bp_release: got rdy=%b r1v=%b want 1 0",
               bus.R0_READY, bus.R1_RVALID);
    else pass++;
    exp_q.push_back('{1'b0, 32'd4});
    tick();
    bus.R0_VALID = 0;
    @(negedge clk);
    tot++; if (bus.ALU_A !== 2)
      $display("FAIL bp_next_alu: got %0h want 2", bus.ALU_A);
    else pass++;
    repeat (3) tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); tot++;
      if (rd >= obs_q.size())
        $display("FAIL bp_sb: got none want %0d:%0h", e.tag, e.data);
      else if (obs_q[rd].tag !== e.tag || obs_q[rd].data !== e.data)
        $display("FAIL bp_sb: got %0d:%0h want %0d:%0h",
                 obs_q[rd].tag, obs_q[rd].data, e.tag, e.data);
      else pass++;
      rd++;
    end
    tot++; if (obs_q.size() != rd)
      $display("FAIL bp_extra: got %0d rsp want %0d", obs_q.size(), rd);
    else pass++;
  endtask

  task automatic test_compare();
    rsp_t        e;
    logic [31:0] va[2];
    logic [31:0] vb[2];
    logic [31:0] vr[2];
    va[0] = 3; vb[0] = 5; vr[0] = 1;
    va[1] = 5; vb[1] = 3; vr[1] = 0;
    bus.R0_RREADY = 1;
    for (int k = 0; k < 2; k++) begin
      bus.R0_VALID = 1; bus.R0_A = va[k]; bus.R0_B = vb[k];
      bus.R0_CTL = LT;
      exp_q.push_back('{1'b0, vr[k]});
      tick();
      bus.R0_VALID = 0; bus.R0_CTL = SUB;
      @(negedge clk);
      tot++; if (bus.ALU_CTL !== LT)
        $display("FAIL cmp_exec_ctl%0d: got %0h want %0h",
                 k, bus.ALU_CTL, LT);
      else pass++;
      tick();
      @(negedge clk);
      tot++; if (bus.ALU_CTL !== LT || bus.R0_RDATA !== vr[k])
        $display("FAIL cmp_resp%0d: got ctl=%0h d=%0h want %0h %0h",
                 k, bus.ALU_CTL, bus.R0_RDATA, LT, vr[k]);
      else pass++;
      tick();
    end
    tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); tot++;
      if (rd >= obs_q.size())
        $display("FAIL cmp_sb: got none want %0d:%0h", e.tag, e.data);
      else if (obs_q[rd].tag !== e.tag || obs_q[rd].data !== e.data)
        $display("FAIL cmp_sb: got %0d:%0h want %0d:%0h",
                 obs_q[rd].tag, obs_q[rd].data, e.tag, e.data);
      else pass++;
      rd++;
    end
    tot++; if (obs_q.size() != rd)
      $display("FAIL cmp_extra: got %0d rsp want %0d", obs_q.size(), rd);
    else pass++;
  endtask

  task automatic test_reset_mid();
    rsp_t e;
    logic seen;
    bus.R1_RREADY = 1; bus.R0_RREADY = 1;
    bus.R1_VALID = 1; bus.R1_A = 9; bus.R1_B = 4; bus.R1_CTL = SUB;
    @(negedge clk);
    tot++; if (bus.R1_READY !== 1)
      $display("FAIL rm_accept: got %b want 1", bus.R1_READY);
    else pass++;
    tick();
    bus.R1_VALID = 0;
    #2;
    rst_n = 0;
    #1;
    tot++; if (bus.R0_RVALID !== 0 || bus.R1_RVALID !== 0)
      $display("FAIL rm_rvalid: got %b%b want 00",
               bus.R0_RVALID, bus.R1_RVALID);
    else pass++;
    tot++; if (bus.ALU_A !== 0 || bus.ALU_B !== 0 || bus.ALU_CTL !== 0)
      $display("FAIL rm_alu: got %0h/%0h/%0h want 0/0/0",
               bus.ALU_A, bus.ALU_B, bus.ALU_CTL);
    else pass++;
    @(posedge clk);
    #1;
    rst_n = 1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.R0_RVALID || bus.R1_RVALID) seen = 1;
      tick();
    end
    tot++; if (seen !== 0)
      $display("FAIL rm_ghost: got rvalid=%b want 0", seen);
    else pass++;
    bus.R0_VALID = 1; bus.R0_A = 1; bus.R0_B = 2; bus.R0_CTL = ADD;
    bus.R1_VALID = 1; bus.R1_A = 8; bus.R1_B = 1; bus.R1_CTL = SUB;
    @(negedge clk);
    tot++; if ({bus.R0_READY, bus.R1_READY} !== 2'b10)
      $display("FAIL rm_first: got %b%b want 10",
               bus.R0_READY, bus.R1_READY);
    else pass++;
    exp_q.push_back('{1'b0, 32'd3});
    tick();
    bus.R0_VALID = 0; bus.R1_VALID = 0;
    repeat (3) tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); tot++;
      if (rd >= obs_q.size())
        $display("FAIL rm_sb: got none want %0d:%0h", e.tag, e.data);
      else if (obs_q[rd].tag !== e.tag || obs_q[rd].data !== e.data)
        $display("FAIL rm_sb: got %0d:%0h want %0d:%0h",
                 obs_q[rd].tag, obs_q[rd].data, e.tag, e.data);
      else pass++;
      rd++;
    end
    tot++; if (obs_q.size() != rd)
      $display("FAIL rm_extra: got %0d rsp want %0d", obs_q.size(), rd);
    else pass++;
  endtask

  task automatic test_dropped();
    rsp_t e;
    logic seen;
    bus.R0_RREADY = 0; bus.R1_RREADY = 1;
    bus.R0_VALID = 1; bus.R0_A = 6; bus.R0_B = 7; bus.R0_CTL = ADD;
    exp_q.push_back('{1'b0, 32'd13});
    tick();
    bus.R0_VALID = 0;
    tick();
    bus.R1_VALID = 1; bus.R1_A = 3; bus.R1_B = 3; bus.R1_CTL = ADD;
    @(negedge clk);
    tot++; if (bus.R1_READY !== 0 || bus.R0_RVALID !== 1)
      $display("FAIL drop_resp: got r1rdy=%b r0v=%b want 0 1",
               bus.R1_READY, bus.R0_RVALID);
    else pass++;
    tick();
    bus.R1_VALID = 0;
    bus.R0_RREADY = 1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.R1_READY || bus.R1_RVALID) seen = 1;
      tick();
    end
    tot++; if (seen !== 0)
      $display("FAIL drop_r1: got %b want 0", seen);
    else pass++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); tot++;
      if (rd >= obs_q.size())
        $display("FAIL drop_sb: got none want %0d:%0h", e.tag, e.data);
      else if (obs_q[rd].tag !== e.tag || obs_q[rd].data !== e.data)
        $display("FAIL drop_sb: got %0d:%0h want %0d:%0h",
                 obs_q[rd].tag, obs_q[rd].data, e.tag, e.data);
      else pass++;
      rd++;
    end
    tot++; if (obs_q.size() != rd)
      $display("FAIL drop_extra: got %0d rsp want %0d", obs_q.size(), rd);
    else pass++;
  endtask

  initial begin
    pass = 0;
    tot  = 0;
    rd   = 0;
    test_reset();
    test_single();
    test_arb();
    test_backpressure();
    test_compare();
    test_reset_mid();
    test_dropped();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

endmodule
